// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding and frame constants.
// Intended for both the receiver and the transmitter so frame format stays in one place.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// RESET_VALUE should match the input's idle level so reset does not look like an edge.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_reg <= RESET_VALUE;
      sync_reg <= RESET_VALUE;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a single-entry holding register and valid/ack handshake.
// Bit timing matches the transmitter's WAIT so loopback is bit-exact.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int WAIT = 868
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      uart_rx,
  input  logic                      ack,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  output logic                      busy,
  output logic                      frame_error,
  output logic                      overrun
);

  localparam int            CW        = $clog2(WAIT) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(WAIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WAIT - 1);

  logic rx_s;

  sync_2ff #(
    .RESET_VALUE(UART_IDLE_LEVEL)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (uart_rx),
    .q    (rx_s)
  );

  uart_rx_state_t            state_reg;
  uart_rx_state_t            state_next;
  logic [CW-1:0]             cnt_reg;
  logic [2:0]                idx_reg;
  logic [UART_DATA_BITS-1:0] shreg_reg;
  logic                      commit_reg;
  logic [UART_DATA_BITS-1:0] data_reg;
  logic                      valid_reg;
  logic                      frame_error_reg;
  logic                      overrun_reg;

  logic start_tick;
  logic bit_tick;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (!rx_s) state_next = START;
      START:   if (start_tick) state_next = rx_s ? IDLE : DATA;
      DATA:    if (bit_tick && idx_reg == 3'd7) state_next = STOP;
      STOP:    if (bit_tick) state_next = rx_s ? IDLE : RECOVER;
      RECOVER: if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    busy       = (state_reg != IDLE);
    start_tick = (state_reg == START) && (cnt_reg == HALF_LAST);
    bit_tick   = ((state_reg == DATA) || (state_reg == STOP)) && (cnt_reg == BIT_LAST);
  end

  // Bit timing and shift register; cnt restarts on every state change and every bit sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg    <= '0;
      idx_reg    <= '0;
      shreg_reg  <= '0;
      commit_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE || state_reg == RECOVER || state_next != state_reg || bit_tick) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      if (state_reg == START) begin
        idx_reg <= '0;
      end else if (state_reg == DATA && bit_tick) begin
        shreg_reg[idx_reg] <= rx_s;
        idx_reg            <= idx_reg + 3'd1;
      end

      commit_reg <= (state_reg == STOP) && bit_tick && rx_s;
    end
  end

  // Holding register and sticky flags; a commit overrides a same-cycle ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_reg        <= '0;
      valid_reg       <= 1'b0;
      frame_error_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      if (ack) begin
        valid_reg       <= 1'b0;
        frame_error_reg <= 1'b0;
        overrun_reg     <= 1'b0;
      end

      if (commit_reg) begin
        if (!valid_reg || ack) begin
          data_reg  <= shreg_reg;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end

      if (state_reg == STOP && bit_tick && !rx_s) begin
        frame_error_reg <= 1'b1;
      end
    end
  end

  assign data        = data_reg;
  assign valid       = valid_reg;
  assign frame_error = frame_error_reg;
  assign overrun     = overrun_reg;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receiver: 8N1 frames on the board's uart_rx pin, LSB first, idle-high line.
- Presents each received byte to the CPU's io-read path through a single-entry holding register with a valid/ack handshake.
- Mirrors the transmitter: same WAIT (clocks per bit) timing, so a transmitter-to-receiver loopback is bit-exact.

Parameters:
WAIT, 868, clock cycles per UART bit period; must be >= 4 and equal to the transmitter's WAIT.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
uart_rx  input  1  serial line, asynchronous to clk, idle high
ack  input  1  CPU consumes the held byte this cycle (io read strobe)
data  output  8  held received byte
valid  output  1  data holds an unconsumed byte
busy  output  1  frame reception in progress (state != IDLE)
frame_error  output  1  sticky: the stop bit was sampled low; cleared by ack
overrun  output  1  sticky: a byte was dropped because valid was still set; cleared by ack

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, data=8'h00, valid=0, busy=0, frame_error=0, overrun=0. Both synchronizer flops reset to 1. Reset mid-frame abandons the frame with no partial output.
- Input sync: uart_rx passes through 2 flops; all logic uses rx_s. This adds 2 cycles of latency.
- States: IDLE, START, DATA, STOP, RECOVER. busy=1 in every state except IDLE.
- Counters: cnt has $clog2(WAIT)+1 bits; bit index is 3 bits.
- IDLE: when rx_s==0, go to START with cnt=0.
- START: when cnt reaches WAIT/2-1 (integer division), sample rx_s.
  - Sample 1: glitch; return to IDLE with no output.
  - Sample 0: go to DATA with cnt=0, idx=0.
- DATA: sample when cnt==WAIT-1, i.e. every WAIT cycles. Shift the bit into shreg[idx] (LSB first), then increment idx. After idx=7 is sampled, go to STOP with cnt=0.
- STOP: sample when cnt==WAIT-1.
  - Sample 1: commit the frame and go to IDLE. The receiver does not wait out the remainder of the stop bit, so back-to-back frames are accepted.
  - Sample 0: set frame_error, commit nothing, go to RECOVER.
- RECOVER: stay until rx_s==1, then go to IDLE. This stops a break or low line from retriggering reception.
- Commit, registered: valid and data update on the cycle after the stop sample.
  - valid==0 or ack==1 that cycle: data<=shreg, valid<=1.
  - valid==1 and ack==0: data unchanged, overrun<=1, and the new byte is dropped.
- ack:
  - Clears valid, overrun and frame_error on the next edge.
  - ack while valid==0 clears only the sticky flags.
  - ack on the same cycle as a commit: the new byte loads, valid stays 1, overrun is not set, and the flags are cleared.
- Timing, measured from the first clk edge where rx_s==0:
  - start sample at +WAIT/2
  - data bit k sample at +WAIT/2+(k+1)*WAIT
  - stop sample at +WAIT/2+9*WAIT
  - valid=1 one cycle later
- Line held low forever: one frame with frame_error=1, then the receiver sits in RECOVER with busy=1.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, STOP, RECOVER}
  - localparam UART_DATA_BITS=8
  - localparam UART_IDLE_LEVEL=1'b1
- The transmitter should adopt this package too.
- One sub-module: sync_2ff. It is a 2-flop synchronizer with a reset-value parameter (1 here) and is reusable for other async inputs.

Test Plan:
1. WAIT=8. Drive frame 0x5A: start 0, bits 0,1,0,1,1,0,1,0, stop 1, each bit 8 cycles. Required: valid=1 exactly 2+4+9*8+1 cycles after the falling edge; data=8'h5A; frame_error=0; busy=0 afterwards.
2. Glitch: uart_rx low for 2 cycles, then high. Required: return to IDLE with valid=0; busy high for at most 4 cycles.
3. Overrun: send 0x11, no ack, then send 0x22. Required: data=8'h11, overrun=1. Then pulse ack. Required: valid=0, overrun=0.
4. Frame error: send 0xA5 with stop bit 0 and hold the line low for 20 cycles. Required: frame_error=1, valid=0, busy=1 until the line goes high, then busy=0.
5. Back-to-back 0x00 then 0xFF with 1 stop bit and ack after each valid. Required: both bytes received correctly, with ack and commit coinciding on the second byte without overrun.
6. Loopback on mother_board: a CPU program writes x1=0x5A to io(0), with the transmitter's uart_tx wired to uart_rx. Required: receiver data=8'h5A, valid=1; reset pulsed mid-frame gives valid=0, busy=0 immediately.
